alu_op_sequencer: RTL and testbench

//  Command-driven master for the W-bit combinational ALU (Control 00 add, 01 sub, 10 ~B, 11 zero).

---
 rtl/alu_op_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer for an external W-bit combinational ALU, with an accumulator and a shift-free multiply built from repeated adds.
// Optional status flags (flag_z, flag_n) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_op_sequencer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic [1:0]   alu_ctrl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic         flag_z,
    output logic         flag_n
`endif
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NOTB = 2'b10;
    localparam logic [1:0] ALU_ZERO = 2'b11;

    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_MLOOP = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t       state_reg, state_next;
    logic [2:0]   op_reg, op_next;
    logic [W-1:0] opnd_reg, opnd_next;
    logic [W-1:0] mcand_reg, mcand_next;
    logic [W-1:0] count_reg, count_next;
    logic [W-1:0] acc_reg, acc_next;
    logic         rsp_valid_reg, rsp_valid_next;
    logic         rsp_err_reg, rsp_err_next;
    logic         acc_we;
    logic         op_illegal;
    logic         cmd_fire;

    assign op_illegal = (op_reg[2:1] == 2'b11);
    assign cmd_fire   = cmd_valid && (state_reg == ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_next = (cmd_op == OP_MUL) ? ST_MLOOP : ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_DONE;
            ST_MLOOP: begin
                if (count_reg == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ALU drive: everything outside an active EXEC/MLOOP step asks for zero
    always_comb begin
        alu_ctrl = ALU_ZERO;
        alu_a    = '0;
        alu_b    = '0;
        case (state_reg)
            ST_EXEC: begin
                case (op_reg)
                    OP_LOAD: begin
                        alu_ctrl = ALU_ADD;
                        alu_b    = opnd_reg;
                    end
                    OP_ADD: begin
                        alu_ctrl = ALU_ADD;
                        alu_a    = acc_reg;
                        alu_b    = opnd_reg;
                    end
                    OP_SUB: begin
                        alu_ctrl = ALU_SUB;
                        alu_a    = acc_reg;
                        alu_b    = opnd_reg;
                    end
                    OP_NOT: begin
                        alu_ctrl = ALU_NOTB;
                        alu_b    = acc_reg;
                    end
                    OP_CLR:  alu_ctrl = ALU_ZERO;
                    default: alu_ctrl = ALU_ZERO;
                endcase
            end
            ST_MLOOP: begin
                if (count_reg != '0) begin
                    alu_ctrl = ALU_ADD;
                    alu_a    = acc_reg;
                    alu_b    = mcand_reg;
                end
            end
            default: alu_ctrl = ALU_ZERO;
        endcase
    end

    // Datapath next values
    always_comb begin
        op_next        = op_reg;
        opnd_next      = opnd_reg;
        mcand_next     = mcand_reg;
        count_next     = count_reg;
        acc_next       = acc_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_err_next   = rsp_err_reg;
        acc_we         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_fire) begin
                    op_next   = cmd_op;
                    opnd_next = cmd_data;
                    if (cmd_op == OP_MUL) begin
                        // Multiply restarts the accumulator and adds the old value cmd_data times
                        mcand_next = acc_reg;
                        count_next = cmd_data;
                        acc_next   = '0;
                        acc_we     = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                if (!op_illegal) begin
                    acc_next = alu_result;
                    acc_we   = 1'b1;
                end
                rsp_valid_next = 1'b1;
                rsp_err_next   = op_illegal;
            end
            ST_MLOOP: begin
                if (count_reg == '0) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b0;
                end else begin
                    acc_next   = alu_result;
                    acc_we     = 1'b1;
                    count_next = count_reg - ONE_W;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rsp_err_next   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_reg        <= '0;
            opnd_reg      <= '0;
            mcand_reg     <= '0;
            count_reg     <= '0;
            acc_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            op_reg        <= op_next;
            opnd_reg      <= opnd_next;
            mcand_reg     <= mcand_next;
            count_reg     <= count_next;
            acc_reg       <= acc_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic flag_z_reg;
    logic flag_n_reg;

    // Flags follow every accumulator write, including the clear at MUL accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_z_reg <= 1'b0;
            flag_n_reg <= 1'b0;
        end else if (acc_we) begin
            flag_z_reg <= (acc_next == '0);
            flag_n_reg <= acc_next[W-1];
        end
    end

    assign flag_z = flag_z_reg;
    assign flag_n = flag_n_reg;
`else
    logic unused_acc_we;
    assign unused_acc_we = acc_we;
`endif

    assign cmd_ready = (state_reg == ST_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = acc_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer against an arithmetic accumulator model.
// Build with ALU_SEQ_FLAGS_EN defined to also check flag_z/flag_n.
module tb_alu_op_sequencer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [1:0]   alu_ctrl;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
    logic         flag_z;
    logic         flag_n;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_acc;
    logic         m_fz;
    logic         m_fn;

    always #5 clk = ~clk;

    alu_op_sequencer #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .flag_z     (flag_z),
        .flag_n     (flag_n)
`endif
    );

    // The external combinational ALU
    always_comb begin
        case (alu_ctrl)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = ~alu_b;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_flags();
`ifdef ALU_SEQ_FLAGS_EN
        check("flag_z", 32'(flag_z), 32'(m_fz));
        check("flag_n", 32'(flag_n), 32'(m_fn));
`endif
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] data, input int hold);
        logic [W-1:0] mcand;
        logic         exp_err;
        int           exp_lat;
        int           edges;
        int           adds;

        mcand   = m_acc;
        exp_err = 1'b0;
        exp_lat = 2;
        case (op)
            3'd0: m_acc = data;
            3'd1: m_acc = m_acc + data;
            3'd2: m_acc = m_acc - data;
            3'd3: m_acc = ~m_acc;
            3'd4: m_acc = '0;
            3'd5: begin
                m_acc   = W'(int'(mcand) * int'(data));
                exp_lat = int'(data) + 2;
            end
            default: exp_err = 1'b1;
        endcase
        if (!exp_err) begin
            m_fz = (m_acc == '0);
            m_fn = m_acc[W-1];
        end

        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = W'($urandom);
        edges = 1;
        adds  = 0;
        while (!rsp_valid && edges < 40) begin
            if (alu_ctrl == 2'b00) begin
                adds++;
                if (op == 3'd5) check("mul_alu_b", 32'(alu_b), 32'(mcand));
            end
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", 32'(edges), 32'(exp_lat));
        check("rsp_data", 32'(rsp_data), 32'(m_acc));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        if (op == 3'd5) check("mul_adds", 32'(adds), 32'(data));
        check_flags();

        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'd0;
            cmd_data  = W'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(m_acc));
            check("hold_err", 32'(rsp_err), 32'(exp_err));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("taken_valid", 32'(rsp_valid), 32'd0);
        check("taken_err", 32'(rsp_err), 32'd0);
        check("taken_cmd_ready", 32'(cmd_ready), 32'd1);
        $display("txn op=%0d data=%0d hold=%0d rsp=%0d err=%0d lat=%0d", op, data, hold, m_acc, exp_err, edges);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd3);
        check_flags();
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        m_acc     = '0;
        m_fz      = 1'b0;
        m_fn      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_cmd(3'd0, 4'd5, 0);
        run_cmd(3'd1, 4'd3, 0);
        run_cmd(3'd0, 4'd2, 0);
        run_cmd(3'd2, 4'd3, 0);
        run_cmd(3'd3, 4'd0, 0);
        run_cmd(3'd0, 4'd3, 0);
        run_cmd(3'd5, 4'd5, 0);
        run_cmd(3'd5, 4'd0, 0);
        run_cmd(3'd0, 4'd7, 0);
        run_cmd(3'd1, 4'd1, 4);
        run_cmd(3'd0, 4'd9, 0);
        run_cmd(3'd6, 4'd2, 2);
        run_cmd(3'd7, 4'd4, 0);
        run_cmd(3'd4, 4'd0, 0);

        // Reset in the middle of a multiply
        run_cmd(3'd0, 4'd3, 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_data  = 4'd7;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_acc = '0;
        m_fz  = 1'b0;
        m_fn  = 1'b0;
        check_reset_state("midmul_reset");
        repeat (12) @(posedge clk);
        #1;
        check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
        $display("txn reset during MUL 7 acc=0");

        run_cmd(3'd5, 4'd5, 0);
        run_cmd(3'd0, 4'd6, 1);

        for (int n = 0; n < 60; n++) begin
            run_cmd(3'($urandom_range(0, 7)), W'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
